// File: rtl/id_scoreboard_if.sv
// Decode-stage hazard scoreboard bundle: ID instruction fields, EX controls and
// scoreboard status. master = pipeline side, slave = scoreboard.
interface id_scoreboard_if #(
    parameter int NUM_FILES = 2,
    parameter int NUM_REGS  = 32,
    parameter int LAT_W     = 3
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int FW = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
    localparam int PW = RW + 1;

    logic                    id_valid;
    logic [2:0]              id_src_en;
    logic [3*FW-1:0]         id_src_file;
    logic [RW-1:0]           id_rs1;
    logic [RW-1:0]           id_rs2;
    logic [RW-1:0]           id_rs3;
    logic                    id_rd_en;
    logic [FW-1:0]           id_rd_file;
    logic [RW-1:0]           id_rd;
    logic [LAT_W-1:0]        id_lat;
    logic                    ex_stall;
    logic                    ex_flush;
    logic                    id_stall;
    logic                    id_issue;
    logic                    sb_busy;
    logic [NUM_FILES*PW-1:0] sb_pending;

    modport master (
        output id_valid, id_src_en, id_src_file, id_rs1, id_rs2, id_rs3,
               id_rd_en, id_rd_file, id_rd, id_lat, ex_stall, ex_flush,
        input  id_stall, id_issue, sb_busy, sb_pending
    );

    modport slave (
        input  id_valid, id_src_en, id_src_file, id_rs1, id_rs2, id_rs3,
               id_rd_en, id_rd_file, id_rd, id_lat, ex_stall, ex_flush,
        output id_stall, id_issue, sb_busy, sb_pending
    );
endinterface

// File: rtl/id_scoreboard.sv
// Per-register countdown scoreboard for in-flight writes across NUM_FILES register files.
// Optional macro SB_WAW_CHECK_EN: stall ID while an older write to the same destination outlives the new one.
module id_scoreboard #(
    parameter int NUM_FILES = 2,
    parameter int NUM_REGS  = 32,
    parameter int LAT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    id_scoreboard_if.slave   sb
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int FW = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
    localparam int PW = RW + 1;

    logic [LAT_W-1:0]        cnt_r     [NUM_FILES][NUM_REGS];
    logic [LAT_W-1:0]        cnt_nxt_s [NUM_FILES][NUM_REGS];
    logic [FW-1:0]           src_file_s [3];
    logic [RW-1:0]           src_idx_s  [3];
    logic                    src_haz_s;
    logic                    waw_s;
    logic                    rd_ok_s;
    logic                    load_s;
    logic                    stall_s;
    logic                    issue_s;
    logic                    busy_s;
    logic [NUM_FILES*PW-1:0] pend_s;
    logic                    busy_r;
    logic [NUM_FILES*PW-1:0] pend_r;

    function automatic logic file_ok(input logic [FW-1:0] f);
        return int'(f) < NUM_FILES;
    endfunction

    // Integer register x0 is hardwired and never reserved nor checked.
    function automatic logic is_x0(input logic [FW-1:0] f, input logic [RW-1:0] r);
        return (f == {FW{1'b0}}) && (r == {RW{1'b0}});
    endfunction

    assign src_idx_s[0]  = sb.id_rs1;
    assign src_idx_s[1]  = sb.id_rs2;
    assign src_idx_s[2]  = sb.id_rs3;
    assign src_file_s[0] = sb.id_src_file[0*FW +: FW];
    assign src_file_s[1] = sb.id_src_file[1*FW +: FW];
    assign src_file_s[2] = sb.id_src_file[2*FW +: FW];

    // Read-after-write hazard on any enabled source.
    always_comb begin
        src_haz_s = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (sb.id_src_en[s] && file_ok(src_file_s[s]) && !is_x0(src_file_s[s], src_idx_s[s]) &&
                (cnt_r[src_file_s[s]][src_idx_s[s]] != {LAT_W{1'b0}})) begin
                src_haz_s = 1'b1;
            end else begin
                src_haz_s = src_haz_s;
            end
        end
    end

    assign rd_ok_s = sb.id_rd_en && file_ok(sb.id_rd_file);

`ifdef SB_WAW_CHECK_EN
    assign waw_s = rd_ok_s && (cnt_r[sb.id_rd_file][sb.id_rd] > sb.id_lat);
`else
    assign waw_s = 1'b0;
`endif

    assign stall_s = sb.id_valid && (src_haz_s || waw_s);
    assign issue_s = sb.id_valid && !stall_s && !sb.ex_stall && !sb.ex_flush;
    assign load_s  = issue_s && rd_ok_s && (sb.id_lat != {LAT_W{1'b0}}) &&
                     !is_x0(sb.id_rd_file, sb.id_rd);

    // Counter next state: freeze on ex_stall, otherwise reservation load beats decrement.
    always_comb begin
        for (int f = 0; f < NUM_FILES; f++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (sb.ex_stall) begin
                    cnt_nxt_s[f][r] = cnt_r[f][r];
                end else if (load_s && (FW'(f) == sb.id_rd_file) && (RW'(r) == sb.id_rd)) begin
                    cnt_nxt_s[f][r] = sb.id_lat;
                end else if (cnt_r[f][r] != {LAT_W{1'b0}}) begin
                    cnt_nxt_s[f][r] = cnt_r[f][r] - {{(LAT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt_s[f][r] = cnt_r[f][r];
                end
            end
        end
    end

    // Status derived from next-state counters so the registered copy is current.
    always_comb begin
        pend_s = {(NUM_FILES*PW){1'b0}};
        for (int f = 0; f < NUM_FILES; f++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (cnt_nxt_s[f][r] != {LAT_W{1'b0}}) begin
                    pend_s[f*PW +: PW] = pend_s[f*PW +: PW] + PW'(1'b1);
                end else begin
                    pend_s[f*PW +: PW] = pend_s[f*PW +: PW];
                end
            end
        end
        busy_s = |pend_s;
    end

    // State and status registers; reset wins over any same-cycle issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NUM_FILES; f++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    cnt_r[f][r] <= {LAT_W{1'b0}};
                end
            end
            busy_r <= 1'b0;
            pend_r <= {(NUM_FILES*PW){1'b0}};
        end else begin
            cnt_r  <= cnt_nxt_s;
            busy_r <= busy_s;
            pend_r <= pend_s;
        end
    end

    assign sb.id_stall   = stall_s;
    assign sb.id_issue   = issue_s;
    assign sb.sb_busy    = busy_r;
    assign sb.sb_pending = pend_r;
endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: expectations queued with each stimulus cycle
// and compared against the DUT on the following falling edge.
module tb_id_scoreboard;
    localparam int K_STALL = 0;
    localparam int K_ISSUE = 1;
    localparam int K_BUSY  = 2;
    localparam int K_PEND  = 3;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    id_scoreboard_if #(.NUM_FILES(2), .NUM_REGS(32), .LAT_W(3)) sb ();
    id_scoreboard #(.NUM_FILES(2), .NUM_REGS(32), .LAT_W(3)) dut (.clk(clk), .rst(rst), .sb(sb));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic exp_cyc(input string tag, input logic stall, input logic issue);
        push_exp({tag, "_stall"}, K_STALL, {31'd0, stall});
        push_exp({tag, "_issue"}, K_ISSUE, {31'd0, issue});
    endtask

    function automatic logic [31:0] pend(input int f0, input int f1);
        return 32'((f1 << 6) | f0);
    endfunction

    // Compare all queued expectations mid-cycle, then advance past the next rising edge.
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_STALL: obs = {31'd0, sb.id_stall};
                K_ISSUE: obs = {31'd0, sb.id_issue};
                K_BUSY:  obs = {31'd0, sb.sb_busy};
                K_PEND:  obs = 32'(sb.sb_pending);
                default: obs = 32'hffff_ffff;
            endcase
            check_val(e.tag, obs, e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [2:0] en, input logic [2:0] files,
                             input int r1, input int r2, input int r3,
                             input logic rd_en, input logic rd_file, input int rd, input int lat);
        sb.id_valid    = 1'b1;
        sb.id_src_en   = en;
        sb.id_src_file = files;
        sb.id_rs1      = 5'(r1);
        sb.id_rs2      = 5'(r2);
        sb.id_rs3      = 5'(r3);
        sb.id_rd_en    = rd_en;
        sb.id_rd_file  = rd_file;
        sb.id_rd       = 5'(rd);
        sb.id_lat      = 3'(lat);
    endtask

    task automatic idle();
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        sb.id_valid = 1'b0;
        sb.ex_stall = 1'b0;
        sb.ex_flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Random traffic, then a held reset.
        for (int i = 0; i < 16; i++) begin
            set_instr(3'($urandom), 3'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 7)));
            sb.ex_stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle();
        set_instr(3'b001, 3'b000, 5, 0, 0, 1'b0, 1'b0, 0, 0);
        exp_cyc("reset", 1'b0, 1'b1);
        push_exp("reset_busy", K_BUSY, 32'd0);
        push_exp("reset_pend", K_PEND, 32'd0);
        tick();

        // RAW on integer x5, latency 3.
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b0, 5, 3);
        exp_cyc("raw_prod", 1'b0, 1'b1);
        tick();
        set_instr(3'b001, 3'b000, 5, 0, 0, 1'b0, 1'b0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            exp_cyc("raw_wait", 1'b1, 1'b0);
            if (i == 1) begin
                push_exp("raw_busy", K_BUSY, 32'd1);
                push_exp("raw_pend", K_PEND, pend(1, 0));
            end
            tick();
        end
        exp_cyc("raw_go", 1'b0, 1'b1);
        push_exp("raw_idle_busy", K_BUSY, 32'd0);
        tick();

        // x0 is never reserved.
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b0, 0, 3);
        exp_cyc("x0_prod", 1'b0, 1'b1);
        tick();
        set_instr(3'b001, 3'b000, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        exp_cyc("x0_dep", 1'b0, 1'b1);
        push_exp("x0_busy", K_BUSY, 32'd0);
        tick();

        // FP f5 latency 4 does not block integer x5; FP rs3 waits.
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b1, 5, 4);
        exp_cyc("fp_prod", 1'b0, 1'b1);
        tick();
        set_instr(3'b001, 3'b000, 5, 0, 0, 1'b0, 1'b0, 0, 0);
        exp_cyc("fp_int_src", 1'b0, 1'b1);
        push_exp("fp_pend", K_PEND, pend(0, 1));
        tick();
        set_instr(3'b100, 3'b100, 0, 0, 5, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_cyc("fp_rs3_wait", 1'b1, 1'b0);
            tick();
        end
        exp_cyc("fp_rs3_go", 1'b0, 1'b1);
        tick();

        // ex_stall freezes counters.
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b0, 7, 2);
        exp_cyc("frz_prod", 1'b0, 1'b1);
        tick();
        set_instr(3'b001, 3'b000, 7, 0, 0, 1'b0, 1'b0, 0, 0);
        sb.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_cyc("frz_hold", 1'b1, 1'b0);
            push_exp("frz_pend", K_PEND, pend(1, 0));
            tick();
        end
        sb.ex_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_cyc("frz_drain", 1'b1, 1'b0);
            tick();
        end
        exp_cyc("frz_go", 1'b0, 1'b1);
        tick();

        // ex_flush kills the reservation but older counters keep running.
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b0, 10, 2);
        exp_cyc("fl_prod", 1'b0, 1'b1);
        tick();
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b0, 9, 5);
        sb.ex_flush = 1'b1;
        exp_cyc("fl_kill", 1'b0, 1'b0);
        push_exp("fl_busy", K_BUSY, 32'd1);
        tick();
        sb.ex_flush = 1'b0;
        set_instr(3'b011, 3'b000, 9, 10, 0, 1'b0, 1'b0, 0, 0);
        exp_cyc("fl_dep_wait", 1'b1, 1'b0);
        push_exp("fl_pend", K_PEND, pend(1, 0));
        tick();
        exp_cyc("fl_dep_go", 1'b0, 1'b1);
        push_exp("fl_busy_end", K_BUSY, 32'd0);
        tick();

        // Back-to-back independent issues, max latency on the last one.
        for (int i = 11; i <= 13; i++) begin
            set_instr(3'b001, 3'b000, 20, 0, 0, 1'b1, 1'b0, i, 7);
            exp_cyc("b2b", 1'b0, 1'b1);
            tick();
        end
        set_instr(3'b001, 3'b000, 13, 0, 0, 1'b0, 1'b0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            exp_cyc("maxlat_wait", 1'b1, 1'b0);
            if (i == 1) push_exp("b2b_pend", K_PEND, pend(3, 0));
            tick();
        end
        exp_cyc("maxlat_go", 1'b0, 1'b1);
        tick();

        // Zero latency: no reservation.
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b0, 3, 0);
        exp_cyc("lat0_prod", 1'b0, 1'b1);
        tick();
        set_instr(3'b001, 3'b000, 3, 0, 0, 1'b0, 1'b0, 0, 0);
        exp_cyc("lat0_dep", 1'b0, 1'b1);
        push_exp("lat0_busy", K_BUSY, 32'd0);
        tick();

        // Write-after-write on f3: older count 6, new latency 2.
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b1, 3, 6);
        exp_cyc("waw_old", 1'b0, 1'b1);
        tick();
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b1, 3, 2);
`ifdef SB_WAW_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            exp_cyc("waw_wait", 1'b1, 1'b0);
            tick();
        end
`endif
        exp_cyc("waw_new", 1'b0, 1'b1);
        tick();
        set_instr(3'b001, 3'b001, 3, 0, 0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            exp_cyc("waw_dep_wait", 1'b1, 1'b0);
            tick();
        end
        exp_cyc("waw_dep_go", 1'b0, 1'b1);
        tick();

        // Mid-operation reset clears reservations and overrides a same-cycle issue.
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b0, 4, 7);
        exp_cyc("mrst_prod", 1'b0, 1'b1);
        tick();
        set_instr(3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b0, 6, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_instr(3'b011, 3'b000, 4, 6, 0, 1'b0, 1'b0, 0, 0);
        exp_cyc("mrst_dep", 1'b0, 1'b1);
        push_exp("mrst_busy", K_BUSY, 32'd0);
        push_exp("mrst_pend", K_PEND, 32'd0);
        tick();

        idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
